// File: rtl/wbarb_pkg.sv
// Shared types and constants for the two-master video framebuffer Wishbone arbiter.
package wbarb_pkg;

  localparam int AW_DEF = 24;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  function automatic logic [1:0] owner_of(input state_e s);
    case (s)
      OWN_A:   return OWNER_A;
      OWN_B:   return OWNER_B;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_video_arbiter_if.sv
// Pipelined Wishbone bus bundle; master drives requests, slave drives responses.
interface wb_video_arbiter_if #(
  parameter int AW = wbarb_pkg::AW_DEF,
  parameter int DW = wbarb_pkg::DW_DEF
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] sel;
  logic          stall;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rdata
  );
endinterface

// File: rtl/wbarb_mux.sv
// Combinational request/response steering between masters A/B and the slave, keyed by owner.
module wbarb_mux
  import wbarb_pkg::*;
(
  input  logic [1:0]          i_owner,
  wb_video_arbiter_if.slave   a_bus,
  wb_video_arbiter_if.slave   b_bus,
  wb_video_arbiter_if.master  s_bus
);

  // Read data is broadcast; only the owner ever sees an ack qualifying it.
  assign a_bus.rdata = s_bus.rdata;
  assign b_bus.rdata = s_bus.rdata;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    s_bus.cyc   = 1'b0;
    s_bus.stb   = 1'b0;
    s_bus.we    = 1'b0;
    s_bus.addr  = '0;
    s_bus.wdata = '0;
    s_bus.sel   = '0;
    a_bus.stall = 1'b1;
    a_bus.ack   = 1'b0;
    a_bus.err   = 1'b0;
    b_bus.stall = 1'b1;
    b_bus.ack   = 1'b0;
    b_bus.err   = 1'b0;

    case (i_owner)
      OWNER_A: begin
        s_bus.cyc   = a_bus.cyc;
        s_bus.stb   = a_bus.stb;
        s_bus.we    = a_bus.we;
        s_bus.addr  = a_bus.addr;
        s_bus.wdata = a_bus.wdata;
        s_bus.sel   = a_bus.sel;
        a_bus.stall = s_bus.stall;
        a_bus.ack   = s_bus.ack;
        a_bus.err   = s_bus.err;
      end
      OWNER_B: begin
        s_bus.cyc   = b_bus.cyc;
        s_bus.stb   = b_bus.stb;
        s_bus.we    = b_bus.we;
        s_bus.addr  = b_bus.addr;
        s_bus.wdata = b_bus.wdata;
        s_bus.sel   = b_bus.sel;
        b_bus.stall = s_bus.stall;
        b_bus.ack   = s_bus.ack;
        b_bus.err   = s_bus.err;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_video_arbiter.sv
// Video-priority two-master Wishbone arbiter with B starvation guard.
// Optional slave watchdog enabled by defining WB_VIDEO_ARBITER_TIMEOUT_EN.
module wb_video_arbiter
  import wbarb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_stall,
  input  logic            i_ack,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data,
  output logic [1:0]      o_owner
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_starve_cnt;
  logic [3:0] r_outstanding;
  logic       w_abort;
  logic       w_inc;
  logic       w_dec;

  wb_video_arbiter_if #(.AW(AW), .DW(DW)) w_a_bus ();
  wb_video_arbiter_if #(.AW(AW), .DW(DW)) w_b_bus ();
  wb_video_arbiter_if #(.AW(AW), .DW(DW)) w_s_bus ();

  assign w_a_bus.cyc   = i_a_cyc;
  assign w_a_bus.stb   = i_a_stb;
  assign w_a_bus.we    = i_a_we;
  assign w_a_bus.addr  = i_a_addr;
  assign w_a_bus.wdata = i_a_data;
  assign w_a_bus.sel   = i_a_sel;
  assign w_b_bus.cyc   = i_b_cyc;
  assign w_b_bus.stb   = i_b_stb;
  assign w_b_bus.we    = i_b_we;
  assign w_b_bus.addr  = i_b_addr;
  assign w_b_bus.wdata = i_b_data;
  assign w_b_bus.sel   = i_b_sel;
  assign w_s_bus.stall = i_stall;
  assign w_s_bus.ack   = i_ack;
  assign w_s_bus.err   = i_err;
  assign w_s_bus.rdata = i_data;

  wbarb_mux u_mux (
    .i_owner (o_owner),
    .a_bus   (w_a_bus),
    .b_bus   (w_b_bus),
    .s_bus   (w_s_bus)
  );

  assign o_owner   = owner_of(r_state);
  assign o_cyc     = w_s_bus.cyc & ~w_abort;
  assign o_stb     = w_s_bus.stb & ~w_abort;
  assign o_we      = w_s_bus.we;
  assign o_addr    = w_s_bus.addr;
  assign o_data    = w_s_bus.wdata;
  assign o_sel     = w_s_bus.sel;
  assign o_a_stall = w_a_bus.stall;
  assign o_a_ack   = w_a_bus.ack;
  assign o_a_err   = w_a_bus.err | (w_abort & (r_state == OWN_A));
  assign o_a_data  = w_a_bus.rdata;
  assign o_b_stall = w_b_bus.stall;
  assign o_b_ack   = w_b_bus.ack;
  assign o_b_err   = w_b_bus.err | (w_abort & (r_state == OWN_B));
  assign o_b_data  = w_b_bus.rdata;

  // Responses only count while the owner still holds cyc; stray acks are ignored.
  assign w_inc = o_stb & ~i_stall & (r_outstanding != 4'hF);
  assign w_dec = (i_ack | i_err) & w_s_bus.cyc & (r_outstanding != 4'h0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_b_cyc && ((r_starve_cnt == STARVE_MAX) || !i_a_cyc)) w_state_next = OWN_B;
        else if (i_a_cyc)                                           w_state_next = OWN_A;
      end
      OWN_A:   if (!i_a_cyc || w_abort) w_state_next = IDLE;
      OWN_B:   if (!i_b_cyc || w_abort) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_starve_cnt  <= '0;
      r_outstanding <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == IDLE) begin
        if (w_state_next == OWN_B)
          r_starve_cnt <= '0;
        else if (w_state_next == OWN_A && i_b_cyc && r_starve_cnt != STARVE_MAX)
          r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (r_state == IDLE || w_abort) r_outstanding <= '0;
      else if (w_inc && !w_dec)       r_outstanding <= r_outstanding + 4'd1;
      else if (w_dec && !w_inc)       r_outstanding <= r_outstanding - 4'd1;
    end
  end

`ifdef WB_VIDEO_ARBITER_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wdog;
  logic       w_wdog_run;

  assign w_wdog_run = (r_state != IDLE) && (r_outstanding != 4'h0) && !i_ack;
  assign w_abort    = w_wdog_run && (r_wdog == WDOG_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                           r_wdog <= '0;
    else if (r_state == IDLE || i_ack || w_abort) r_wdog <= '0;
    else if (w_wdog_run)                      r_wdog <= r_wdog + 8'd1;
  end
`else
  assign w_abort = 1'b0;
`endif

endmodule

// File: tb/tb_wb_video_arbiter.sv
// Scoreboard bench for wb_video_arbiter: directed master traffic, slave model, response queues.
module tb_wb_video_arbiter;
  import wbarb_pkg::*;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT = 16;

  typedef struct { bit is_err; bit chk_data; logic [DW-1:0] data; } resp_t;
  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW/8-1:0] sel; } txn_t;
  typedef struct { int due; logic [DW-1:0] data; bit err; } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] owner;
  logic [1:0] prev_owner = 2'b00;

  wb_video_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  wb_video_arbiter_if #(.AW(AW), .DW(DW)) b_if ();
  wb_video_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  resp_t exp_a[$];
  resp_t exp_b[$];
  txn_t  exp_s[$];
  pend_t pend[$];
  bit slave_mute = 1'b0;
  int err_idx = -1;
  int slave_idx = 0;
  int a_acks = 0, a_errs = 0, b_acks = 0, b_errs = 0;
  int a_grants = 0, a_grants_at_b = -1;

  wb_video_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_cyc(a_if.cyc), .i_a_stb(a_if.stb), .i_a_we(a_if.we), .i_a_addr(a_if.addr),
    .i_a_data(a_if.wdata), .i_a_sel(a_if.sel),
    .o_a_stall(a_if.stall), .o_a_ack(a_if.ack), .o_a_err(a_if.err), .o_a_data(a_if.rdata),
    .i_b_cyc(b_if.cyc), .i_b_stb(b_if.stb), .i_b_we(b_if.we), .i_b_addr(b_if.addr),
    .i_b_data(b_if.wdata), .i_b_sel(b_if.sel),
    .o_b_stall(b_if.stall), .o_b_ack(b_if.ack), .o_b_err(b_if.err), .o_b_data(b_if.rdata),
    .o_cyc(s_if.cyc), .o_stb(s_if.stb), .o_we(s_if.we), .o_addr(s_if.addr),
    .o_data(s_if.wdata), .o_sel(s_if.sel),
    .i_stall(s_if.stall), .i_ack(s_if.ack), .i_err(s_if.err), .i_data(s_if.rdata),
    .o_owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int resp_pending(input bit is_b);
    return is_b ? exp_b.size() : exp_a.size();
  endfunction

  task automatic resp_check(input bit is_b, input logic ack, input logic err, input logic [DW-1:0] data);
    resp_t r;
    string t = is_b ? "b_resp" : "a_resp";
    if (resp_pending(is_b) == 0) begin
      check({t, "_unexpected"}, {ack, err}, 2'b00);
      return;
    end
    r = is_b ? exp_b.pop_front() : exp_a.pop_front();
    check({t, "_err"}, err, r.is_err);
    check({t, "_ack"}, ack, !r.is_err);
    if (r.chk_data && !r.is_err) check({t, "_data"}, data, r.data);
  endtask

  task automatic drive(input bit is_b, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (is_b) begin
      b_if.cyc = cyc; b_if.stb = stb; b_if.we = we; b_if.addr = addr; b_if.wdata = data; b_if.sel = 4'hF;
    end else begin
      a_if.cyc = cyc; a_if.stb = stb; a_if.we = we; a_if.addr = addr; a_if.wdata = data; a_if.sel = 4'hF;
    end
  endtask

  // Pipelined burst: expectations queued at acceptance, responses drained, then cyc dropped for one cycle.
  task automatic burst(input bit is_b, input logic [AW-1:0] base, input int n, input logic we,
                       input logic [DW-1:0] wdata, input int err_at);
    int i = 0;
    int budget = 0;
    logic [DW-1:0] d = we ? wdata : '0;
    drive(is_b, 1'b1, 1'b1, we, base, d);
    while (i < n && budget < 300) begin
      @(negedge clk);
      budget++;
      if (!(is_b ? b_if.stall : a_if.stall)) begin
        exp_s.push_back('{we: we, addr: AW'(base + AW'(i)), data: d, sel: 4'hF});
        if (is_b) exp_b.push_back('{is_err: (i == err_at), chk_data: !we, data: {8'h5A, AW'(base + AW'(i))}});
        else      exp_a.push_back('{is_err: (i == err_at), chk_data: !we, data: {8'h5A, AW'(base + AW'(i))}});
        i++;
      end
      @(posedge clk); #1;
      if (i < n) drive(is_b, 1'b1, 1'b1, we, AW'(base + AW'(i)), d);
      else       drive(is_b, 1'b1, 1'b0, we, base, d);
    end
    check(is_b ? "b_accepted" : "a_accepted", i, n);
    budget = 0;
    while (resp_pending(is_b) != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check(is_b ? "b_resp_drained" : "a_resp_drained", resp_pending(is_b), 0);
    @(posedge clk); #1;
    drive(is_b, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  // Response monitor and non-owner isolation checks.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (owner == OWNER_A && prev_owner != OWNER_A) a_grants++;
      if (owner == OWNER_B && prev_owner != OWNER_B) a_grants_at_b = a_grants;
      if (owner != OWNER_A) check("a_stall_not_owner", a_if.stall, 1'b1);
      if (owner != OWNER_B) check("b_stall_not_owner", b_if.stall, 1'b1);
      if (s_if.ack || s_if.err) check("ack_inside_cycle", s_if.cyc, 1'b1);
      if (a_if.ack || a_if.err) begin
        a_acks += int'(a_if.ack); a_errs += int'(a_if.err);
        resp_check(1'b0, a_if.ack, a_if.err, a_if.rdata);
      end
      if (b_if.ack || b_if.err) begin
        b_acks += int'(b_if.ack); b_errs += int'(b_if.err);
        resp_check(1'b1, b_if.ack, b_if.err, b_if.rdata);
      end
    end
    prev_owner = owner;
  end

  // Slave model: never stalls, answers two cycles after acceptance with data derived from the address.
  initial begin
    txn_t  seen;
    pend_t p;
    bit    got;
    s_if.stall = 1'b0; s_if.ack = 1'b0; s_if.err = 1'b0; s_if.rdata = '0;
    forever begin
      @(negedge clk);
      got  = rst_n && s_if.cyc && s_if.stb && !s_if.stall;
      seen = '{we: s_if.we, addr: s_if.addr, data: s_if.wdata, sel: s_if.sel};
      @(posedge clk); #1;
      if (!rst_n) pend.delete();
      else if (got) begin
        check("slave_txn_expected", exp_s.size() != 0, 1'b1);
        if (exp_s.size() != 0) check("slave_txn", seen, exp_s.pop_front());
        if (!slave_mute) pend.push_back('{due: cyc_cnt + 1, data: {8'h5A, seen.addr}, err: (slave_idx == err_idx)});
        slave_idx++;
      end
      s_if.ack = 1'b0;
      s_if.err = 1'b0;
      if (pend.size() != 0 && pend[0].due == cyc_cnt) begin
        p = pend.pop_front();
        s_if.ack = !p.err; s_if.err = p.err; s_if.rdata = p.data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int budget;
    int c0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);

    // Reset held with both masters requesting.
    repeat (3) @(negedge clk);
    check("rst_o_cyc", s_if.cyc, 1'b0);
    check("rst_owner", owner, OWNER_NONE);
    check("rst_a_stall", a_if.stall, 1'b1);
    check("rst_b_stall", b_if.stall, 1'b1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_owner", owner, OWNER_A);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // A-only pipelined burst.
    a_acks = 0; b_acks = 0;
    burst(1'b0, 24'h000100, 8, 1'b0, '0, -1);
    @(negedge clk);
    check("a_burst_owner_idle", owner, OWNER_NONE);
    check("a_burst_acks", a_acks, 8);
    check("a_burst_b_acks", b_acks, 0);
    @(posedge clk); #1;

    // Slave error on B's second of three transfers.
    a_acks = 0; a_errs = 0; b_errs = 0; b_acks = 0;
    err_idx = slave_idx + 1;
    burst(1'b1, 24'h000020, 3, 1'b0, '0, 1);
    err_idx = -1;
    @(negedge clk);
    check("err_owner_idle", owner, OWNER_NONE);
    check("err_b_errs", b_errs, 1);
    check("err_b_acks", b_acks, 2);
    check("err_a_quiet", a_acks + a_errs, 0);
    @(posedge clk); #1;

    // Starvation: B waits with cyc high while A runs back-to-back single reads.
    a_grants = 0; a_grants_at_b = -1;
    fork
      burst(1'b1, 24'h000010, 1, 1'b1, 32'hDEADBEEF, -1);
      begin
        for (int k = 0; k < 5; k++) burst(1'b0, AW'(24'h000200 + k), 1, 1'b0, '0, -1);
      end
    join
    check("starve_a_grants", a_grants_at_b, STARVE_LIMIT);

    // Simultaneous request from IDLE with the starvation count cleared.
    fork
      burst(1'b0, 24'h000300, 2, 1'b0, '0, -1);
      burst(1'b1, 24'h000400, 1, 1'b0, '0, -1);
      begin
        repeat (2) @(negedge clk);
        check("simul_owner", owner, OWNER_A);
        check("simul_b_stall", b_if.stall, 1'b1);
      end
    join

    // Reset in the middle of an outstanding read.
    slave_mute = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h000500, '0);
    budget = 0;
    do begin @(negedge clk); budget++; end while (a_if.stall && budget < 20);
    check("midrst_accepted", a_if.stall, 1'b0);
    exp_s.push_back('{we: 1'b0, addr: 24'h000500, data: '0, sel: 4'hF});
    @(posedge clk); #1;
    a_if.stb = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cyc_before_edge", s_if.cyc, 1'b1);
    @(posedge clk); #1;
    a_if.cyc = 1'b0;
    @(negedge clk);
    check("midrst_cyc", s_if.cyc, 1'b0);
    check("midrst_owner", owner, OWNER_NONE);
    @(posedge clk); #1;
    rst_n = 1'b1; slave_mute = 1'b0;
    exp_a.delete();
    @(posedge clk); #1;

`ifdef WB_VIDEO_ARBITER_TIMEOUT_EN
    // Slave never answers an A read; the watchdog must abort it.
    slave_mute = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 24'h000600, '0);
    budget = 0;
    do begin @(negedge clk); budget++; end while (a_if.stall && budget < 20);
    c0 = cyc_cnt;
    exp_s.push_back('{we: 1'b0, addr: 24'h000600, data: '0, sel: 4'hF});
    exp_a.push_back('{is_err: 1'b1, chk_data: 1'b0, data: '0});
    @(posedge clk); #1;
    a_if.stb = 1'b0;
    budget = 0;
    do begin @(negedge clk); budget++; end while (!a_if.err && budget < 40);
    check("to_latency", cyc_cnt - c0, TIMEOUT);
    check("to_o_cyc", s_if.cyc, 1'b0);
    @(negedge clk);
    check("to_owner", owner, OWNER_NONE);
    @(posedge clk); #1;
    a_if.cyc = 1'b0; slave_mute = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`else
    c0 = cyc_cnt;
    budget = c0;
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
